ex_mem_skid_stage: RTL and testbench

- Parametrised successor to the current EX/MEM latch: a clocked ready/valid pipeline stage carrying control and datapath fields from EX to MEM.
- Adds back-pressure through a 2-entry skid buffer, a registered in_ready, synchronous flush for bubble insertion, and forced-zero control on bubbles.
- Sits between the ALU/forwarding logic and the data-memory interface. Memory stalls propagate upstream without a combinational path from out_ready to in_ready.

---
 rtl/ex_mem_skid_stage_pkg.sv | 15 +
 rtl/ex_mem_skid_stage_skid_buf.sv | 66 ++++++
 rtl/ex_mem_skid_stage.sv | 57 +++++
 tb/tb_ex_mem_skid_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_stage_pkg.sv
// mips_pipe_pkg: shared EX/MEM control bit positions, default widths and payload layout
package mips_pipe_pkg;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_W = 3;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } ex_mem_payload_t;
endpackage

// File: rtl/ex_mem_skid_stage_skid_buf.sv
// pipe_skid_buf: 2-entry skid buffer with registered in_ready and synchronous flush
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic         accept, emit;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);
  assign accept    = in_valid && in_ready;
  assign emit      = main_valid_q && out_ready;

  // next-state: drain skid into main first, otherwise refill main or park the new entry in skid
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (emit) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || emit) begin
      main_valid_d = accept;
      main_data_d  = accept ? in_data : main_data_q;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // state registers with active-low synchronous reset clearing valids and payloads
  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  a_skid_implies_main: assert property (@(posedge clk) disable iff (!reset) !(skid_valid_q && !main_valid_q));
endmodule

// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX/MEM ready/valid stage with skid buffer, flush and bubble-masked control
module ex_mem_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = mips_pipe_pkg::DATA_W,
  parameter int REG_W  = mips_pipe_pkg::REG_W,
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu,
  output logic [REG_W-1:0]  out_wreg,
  output logic [DATA_W-1:0] out_wdata,
  output logic [1:0]        occupancy
);
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } payload_t;

  payload_t in_p, out_p;

  assign in_p = '{ctrl: in_ctrl, alu: in_alu, wreg: in_wreg, wdata: in_wdata};

  pipe_skid_buf #(.W($bits(payload_t))) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_p),
    .occupancy (occupancy)
  );

  assign out_ctrl  = out_valid ? out_p.ctrl : '0;
  assign out_alu   = out_p.alu;
  assign out_wreg  = out_p.wreg;
  assign out_wdata = out_p.wdata;

  a_bubble_ctrl: assert property (@(posedge clk) disable iff (!reset)
    !out_valid |-> !out_ctrl[CTRL_REGWRITE] && !out_ctrl[CTRL_MEMWRITE] && !out_ctrl[CTRL_MEMTOREG]);
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: directed checks of reset, streaming, back-pressure, flush and bubble masking
module tb_ex_mem_skid_stage;
  logic        clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [2:0]  in_ctrl = 0, out_ctrl;
  logic [31:0] in_alu = 0, in_wdata = 0, out_alu, out_wdata;
  logic [4:0]  in_wreg = 0, out_wreg;
  logic [1:0]  occupancy;
  int          checks = 0, errors = 0;

  ex_mem_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_alu(in_alu), .in_wreg(in_wreg), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_alu(out_alu),
    .out_wreg(out_wreg), .out_wdata(out_wdata), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [2:0] ctrl);
    in_valid = 1;
    in_alu   = alu;
    in_ctrl  = ctrl;
    in_wreg  = alu[4:0];
    in_wdata = ~alu;
  endtask

  initial begin
    send(32'h55, 3'b111);
    out_ready = 1;
    tick();
    tick();
    reset = 1;
    in_valid = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_alu", out_alu, 0);
    chk("rst_out_wreg", out_wreg, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_occ", occupancy, 0);

    send(32'h10, 3'b001);
    tick();
    chk("s1_alu", out_alu, 32'h10);
    chk("s1_valid", out_valid, 1);
    chk("s1_ctrl", out_ctrl, 3'b001);
    chk("s1_wreg", out_wreg, 5'h10);
    chk("s1_wdata", out_wdata, 32'hFFFF_FFEF);
    chk("s1_in_ready", in_ready, 1);
    send(32'h20, 3'b011);
    tick();
    chk("s2_alu", out_alu, 32'h20);
    chk("s2_ctrl", out_ctrl, 3'b011);
    chk("s2_in_ready", in_ready, 1);
    send(32'h30, 3'b101);
    tick();
    chk("s3_alu", out_alu, 32'h30);
    chk("s3_occ", occupancy, 1);
    chk("s3_in_ready", in_ready, 1);
    in_valid = 0;
    tick();
    chk("s_drain_valid", out_valid, 0);
    chk("s_drain_occ", occupancy, 0);

    in_ctrl = 3'b111;
    in_alu  = 32'hBAD;
    tick();
    chk("bub_valid", out_valid, 0);
    chk("bub_ctrl", out_ctrl, 0);
    chk("bub_alu_kept", out_alu, 32'h30);

    out_ready = 0;
    send(32'hA, 3'b010);
    tick();
    chk("bp_a_occ", occupancy, 1);
    chk("bp_a_alu", out_alu, 32'hA);
    chk("bp_a_ctrl", out_ctrl, 3'b010);
    send(32'hB, 3'b100);
    tick();
    chk("bp_b_occ", occupancy, 2);
    chk("bp_b_in_ready", in_ready, 0);
    chk("bp_b_alu", out_alu, 32'hA);
    send(32'hC, 3'b001);
    tick();
    chk("bp_c_held_occ", occupancy, 2);
    chk("bp_c_held_alu", out_alu, 32'hA);
    out_ready = 1;
    tick();
    chk("bp_out_b", out_alu, 32'hB);
    chk("bp_out_b_ctrl", out_ctrl, 3'b100);
    chk("bp_out_b_occ", occupancy, 1);
    chk("bp_out_b_in_ready", in_ready, 1);
    tick();
    chk("bp_out_c", out_alu, 32'hC);
    chk("bp_out_c_ctrl", out_ctrl, 3'b001);
    in_valid = 0;
    tick();
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_occ", occupancy, 0);

    out_ready = 0;
    send(32'h1, 3'b001);
    tick();
    send(32'h2, 3'b001);
    tick();
    chk("fl_pre_occ", occupancy, 2);
    send(32'hDEAD, 3'b111);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("fl_no_dead", {31'b0, out_alu == 32'hDEAD}, 0);
      chk("fl_stay_empty", out_valid, 0);
      tick();
    end

    out_ready = 0;
    send(32'h3, 3'b011);
    tick();
    send(32'h4, 3'b011);
    tick();
    chk("mr_pre_occ", occupancy, 2);
    out_ready = 1;
    tick();
    out_ready = 0;
    reset = 0;
    send(32'h5, 3'b111);
    tick();
    reset = 1;
    in_valid = 0;
    chk("mr_valid", out_valid, 0);
    chk("mr_ctrl", out_ctrl, 0);
    chk("mr_alu", out_alu, 0);
    chk("mr_wreg", out_wreg, 0);
    chk("mr_wdata", out_wdata, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_in_ready", in_ready, 1);
    out_ready = 1;
    send(32'h77, 3'b011);
    tick();
    in_valid = 0;
    chk("mr_fresh_alu", out_alu, 32'h77);
    chk("mr_fresh_valid", out_valid, 1);
    chk("mr_fresh_ctrl", out_ctrl, 3'b011);
    chk("mr_fresh_wreg", out_wreg, 5'h17);
    chk("mr_fresh_wdata", out_wdata, 32'hFFFF_FF88);
    tick();
    chk("mr_fresh_drain", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
